// File: rtl/systolic_pkg.sv
// systolic_pkg: shared drain FSM states and accumulator width
package systolic_pkg;
    localparam int ACC_W = 32;
    typedef enum logic [1:0] {IDLE, SETTLE, STREAM} state_t;
endpackage

// File: rtl/systolic_drain.sv
// systolic_drain: settle, snapshot and stream out a PE-array accumulator tile
module systolic_drain import systolic_pkg::*; #(
    parameter int N_ROWS    = 14,
    parameter int N_COLS    = 14,
    parameter int LANES     = 2,
    parameter int DRAIN_LAT = N_ROWS + N_COLS - 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
    input  logic [N_ROWS*N_COLS*ACC_W-1:0]  c_in_flat,
    output logic                            acc_clr,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [LANES*ACC_W-1:0]          m_data,
    output logic                            m_last,
    output logic                            busy,
    output logic                            done
);
    localparam int N_BEATS = N_ROWS * N_COLS / LANES;
    localparam int BW      = N_BEATS > 1 ? $clog2(N_BEATS) : 1;
    localparam int CW      = DRAIN_LAT > 0 ? $clog2(DRAIN_LAT + 1) : 1;

    state_t                           state, state_nxt;
    logic [CW-1:0]                    cnt, cnt_nxt;
    logic [BW-1:0]                    beat, beat_nxt;
    logic                             snap, done_nxt, last_beat;
    logic [N_ROWS*N_COLS*ACC_W-1:0]   shadow;

    // Beats are contiguous LANES-element runs of the row-major tile, so beat k starts at element k*LANES
    assign last_beat = beat == BW'(N_BEATS - 1);
    assign m_valid   = state == STREAM;
    assign m_last    = m_valid && last_beat;
    assign m_data    = m_valid ? shadow[int'(beat)*LANES*ACC_W +: LANES*ACC_W] : '0;
    assign busy      = state != IDLE;

    // Next-state logic: abort wins over start, snapshot and handshake
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        beat_nxt  = beat;
        snap      = 1'b0;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            beat_nxt  = '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (DRAIN_LAT == 0) begin
                        snap      = 1'b1;
                        state_nxt = STREAM;
                    end else begin
                        cnt_nxt   = CW'(DRAIN_LAT);
                        state_nxt = SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        snap      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = STREAM;
                    end
                end
                STREAM: if (m_ready) begin
                    beat_nxt = last_beat ? '0 : beat + BW'(1);
                    if (last_beat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            beat    <= '0;
            acc_clr <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            beat    <= beat_nxt;
            acc_clr <= snap;
            done    <= done_nxt;
        end
    end

    // Shadow copy of the array, isolated from later c_in_flat changes
    always_ff @(posedge clk) begin
        if (snap) shadow <= c_in_flat;
    end
endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed checks of the drain FSM on a 4x4 tile
module tb_systolic_drain;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [511:0]   c_in_flat;
    logic           acc_clr, m_valid, m_ready, m_last, busy, done;
    logic [63:0]    m_data;
    int             n_cmp = 0;
    int             n_err = 0;

    systolic_drain #(.N_ROWS(4), .N_COLS(4), .LANES(2), .DRAIN_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .c_in_flat(c_in_flat),
        .acc_clr(acc_clr), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int k);
        int r, c0;
        r  = k / 2;
        c0 = (k % 2) * 2;
        return {32'(r * 16 + c0 + 1), 32'(r * 16 + c0)};
    endfunction

    task automatic load_tile();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                c_in_flat[(r*4+c)*32 +: 32] = 32'(r * 16 + c);
    endtask

    task automatic start_drain(input bit poison);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("settle_busy", busy, 1);
            check("settle_valid", m_valid, 0);
            check("settle_clr", acc_clr, 0);
            @(negedge clk);
        end
        check("settle_clr_last", acc_clr, 0);
        @(negedge clk);
        check("snap_clr", acc_clr, 1);
        check("snap_valid", m_valid, 1);
        if (poison) c_in_flat = '1;
    endtask

    task automatic run_stream(input bit bp, input int stop_at, input bit poke_start);
        int nb, cyc;
        bit rdy;
        nb = 0; cyc = 0; rdy = 1'b0;
        while (nb < stop_at && cyc < 100) begin
            if (cyc > 0) check("stream_clr", acc_clr, 0);
            check("stream_valid", m_valid, 1);
            check($sformatf("beat%0d_data", nb), m_data, exp_beat(nb));
            check($sformatf("beat%0d_last", nb), m_last, nb == 7);
            start = poke_start && cyc == 3;
            rdy = bp ? ~rdy : 1'b1;
            m_ready = rdy;
            if (m_valid && rdy) nb++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("stream_beats", nb, stop_at);
        if (stop_at == 8) begin
            m_ready = 1'b0;
            check("done_pulse", done, 1);
            check("end_valid", m_valid, 0);
            check("end_busy", busy, 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("done_once", done, 0);
                check("idle_valid", m_valid, 0);
            end
        end
    endtask

    initial begin
        m_ready = 1'b0;
        load_tile();
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_last", m_last, 0);
        check("rst_clr", acc_clr, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        start_drain(1'b0);
        run_stream(1'b0, 8, 1'b0);

        start_drain(1'b0);
        run_stream(1'b1, 8, 1'b0);

        start_drain(1'b1);
        run_stream(1'b0, 8, 1'b0);
        load_tile();

        start_drain(1'b0);
        run_stream(1'b0, 4, 1'b0);
        abort = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_ready = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        check("abort_done_late", done, 0);
        check("abort_clr", acc_clr, 0);
        start_drain(1'b0);
        run_stream(1'b0, 8, 1'b0);

        start_drain(1'b0);
        run_stream(1'b0, 8, 1'b1);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_clr", acc_clr, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_clr", acc_clr, 0);
            check("post_rst_busy", busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 SHALL have parameter N_ROWS, default 14: PE grid rows.
REQ-002 SHALL have parameter N_COLS, default 14: PE grid columns.
REQ-003 SHALL have parameter LANES, default 2: accumulators per output beat; N_COLS % LANES == 0.
REQ-004 SHALL have parameter DRAIN_LAT, default N_ROWS+N_COLS-1: settle cycles before snapshot.
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: request drain of the current tile.
REQ-008 SHALL have port abort, input, 1: synchronous cancel, return to idle.
REQ-009 SHALL have port c_in_flat, input, N_ROWS*N_COLS*32: array accumulators, row-major, element (r,c) at bits [(r*N_COLS+c)*32 +: 32].
REQ-010 SHALL have port acc_clr, output, 1: one-cycle clear pulse to the array.
REQ-011 SHALL have port m_valid, output, 1: output beat valid.
REQ-012 SHALL have port m_ready, input, 1: downstream accepts the beat.
REQ-013 SHALL have port m_data, output, LANES*32: output beat, lane l at bits [l*32 +: 32].
REQ-014 SHALL have port m_last, output, 1: final beat of the tile.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the final handshake.

Function
REQ-017 SHALL implement states IDLE, SETTLE, STREAM.
REQ-018 IDLE: start=1 SHALL load settle counter with DRAIN_LAT and go to SETTLE; if DRAIN_LAT==0, go directly to the capture action.
REQ-019 SETTLE: counter SHALL decrement each cycle; in the cycle it reaches 0, c_in_flat SHALL be copied into an internal shadow buffer and the state SHALL become STREAM.
REQ-020 acc_clr SHALL pulse high for exactly the one cycle after the snapshot cycle.
REQ-021 STREAM: m_valid SHALL be 1; beat k SHALL carry elements row = k/(N_COLS/LANES), cols (k%(N_COLS/LANES))*LANES .. +LANES-1, lowest column in lane 0.
REQ-022 A beat SHALL transfer only when m_valid & m_ready; the beat index SHALL advance by exactly 1 per transfer.
REQ-023 m_data and m_last SHALL stay stable while m_valid & !m_ready.
REQ-024 m_last SHALL be 1 only on beat N_ROWS*N_COLS/LANES-1.
REQ-025 On the m_last transfer, the next cycle SHALL have state IDLE, m_valid=0, done=1 for one cycle.
REQ-026 start SHALL be ignored when busy=1.
REQ-027 abort=1 in any state SHALL force IDLE next cycle: m_valid=0, no done pulse, no acc_clr pulse issued afterwards. Abort has priority over start and over a same-cycle handshake.
REQ-028 Shadow buffer contents SHALL be unaffected by c_in_flat changes after the snapshot.
REQ-029 Data SHALL pass bit-exact; no rounding, saturation or sign change.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, counters 0, m_valid 0, m_last 0, m_data 0, acc_clr 0, busy 0, done 0.
REQ-031 Reset mid-STREAM SHALL discard the tile; after release the block SHALL wait for a new start.
REQ-032 The shadow buffer need not be reset.

Structure
REQ-033 The state enum and ACC_W=32 SHALL live in shared package systolic_pkg.
REQ-034 The block SHALL be a single module with no sub-module; the beat counter and shadow buffer are inline.

Verification (N_ROWS=N_COLS=4, LANES=2, DRAIN_LAT=3, c(r,c)=r*16+c)
REQ-035 Basic drain: start pulse with m_ready=1 -> snapshot 3 cycles later, acc_clr pulse next cycle, 8 beats; beat 0 = {1,0}, beat 7 = {0x33,0x32} with m_last; done pulse 1 cycle after beat 7.
REQ-036 Backpressure: m_ready toggling 1/0 each cycle -> each beat held stable while stalled, 8 transfers total, identical data to REQ-035.
REQ-037 Snapshot isolation: set c_in_flat to all 0xFFFFFFFF one cycle after the snapshot -> streamed data still equals r*16+c.
REQ-038 Abort: assert abort after beat 3 transfers -> m_valid=0 next cycle, no done pulse; a following start drains all 8 beats correctly.
REQ-039 Start while busy: pulse start during STREAM -> ignored, exactly 8 beats and one done pulse.
REQ-040 Reset mid-SETTLE: assert rst_n low -> all outputs 0 immediately, no acc_clr pulse after release.
